// File: rtl/arbiter_rr_burst.sv
// N-port sdram arbiter: fixed-priority or round-robin selection with burst-limited grant hold.
// Read return data is steered back to the owning port by its id tag.
module arbiter_rr_burst #(
    parameter int N     = 4,
    parameter int AN    = 24,
    parameter int DN    = 16,
    parameter int IDN   = $clog2(N),
    parameter int MODE  = 1,
    parameter int BURST = 8
) (
    input  logic            clk,
    input  logic            n_reset,
    input  logic [N-1:0]    req,
    input  logic [N*AN-1:0] addr,
    input  logic [N*DN-1:0] data,
    input  logic [N-1:0]    wr,
    output logic [N-1:0]    ack,
    output logic [N-1:0]    valid,
    output logic [DN-1:0]   rdata,
    output logic            mem_req,
    output logic [AN-1:0]   mem_addr,
    output logic [DN-1:0]   mem_data,
    output logic            mem_wr,
    output logic [IDN-1:0]  mem_id,
    input  logic            mem_ack,
    input  logic [DN-1:0]   mem_rdata,
    input  logic            mem_rvalid,
    input  logic [IDN-1:0]  mem_rid
);
    localparam int CW = $clog2(BURST + 1);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_GRANT = 1'b1} st_t;

    st_t            st_q, st_d;
    logic [IDN-1:0] gnt_q, gnt_d;
    logic [IDN-1:0] ptr_q, ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [N-1:0]   scan_s;
    logic [IDN:0]   rot_idx_s;
    logic [IDN-1:0] base_s, off_s, win_s, gnt_nxt_s;
    logic [IDN:0]   win_sum_s;
    logic [CW-1:0]  cnt_inc_s;
    logic           gnt_req_s, granted_s;

    // Winner selection: scan requests starting at base, the lowest offset wins, result wraps mod N.
    always_comb begin
        scan_s    = '0;
        base_s    = '0;
        rot_idx_s = '0;
        for (int i = 0; i < N; i++) begin
            rot_idx_s = {1'b0, ptr_q} + (IDN+1)'(i);
            if (rot_idx_s >= (IDN+1)'(N)) begin
                rot_idx_s = rot_idx_s - (IDN+1)'(N);
            end else begin
                rot_idx_s = rot_idx_s;
            end
            if (MODE == 1) begin
                scan_s[i] = req[rot_idx_s[IDN-1:0]];
            end else begin
                scan_s[i] = req[i];
            end
        end
        if (MODE == 1) begin
            base_s = ptr_q;
        end else begin
            base_s = '0;
        end
        off_s = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (scan_s[i]) begin
                off_s = IDN'(i);
            end else begin
                off_s = off_s;
            end
        end
        win_sum_s = {1'b0, base_s} + {1'b0, off_s};
        if (win_sum_s >= (IDN+1)'(N)) begin
            win_s = IDN'(win_sum_s - (IDN+1)'(N));
        end else begin
            win_s = win_sum_s[IDN-1:0];
        end
    end

    // Next-state: arbitrate in IDLE, hold the grant until the burst limit or the port lets go.
    always_comb begin
        st_d      = st_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_req_s = req[gnt_q];
        cnt_inc_s = cnt_q + CW'(1);
        if (gnt_q == IDN'(N - 1)) begin
            gnt_nxt_s = '0;
        end else begin
            gnt_nxt_s = gnt_q + IDN'(1);
        end
        case (st_q)
            ST_IDLE: begin
                if (|req) begin
                    st_d  = ST_GRANT;
                    gnt_d = win_s;
                    cnt_d = '0;
                end else begin
                    st_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (mem_ack) begin
                    cnt_d = cnt_inc_s;
                    if (cnt_inc_s == CW'(BURST)) begin
                        st_d  = ST_IDLE;
                        ptr_d = gnt_nxt_s;
                    end else begin
                        st_d = ST_GRANT;
                    end
                end else if (!gnt_req_s) begin
                    st_d  = ST_IDLE;
                    ptr_d = gnt_nxt_s;
                end else begin
                    st_d = ST_GRANT;
                end
            end
            default: begin
                st_d = ST_IDLE;
            end
        endcase
    end

    // Memory-side mux and per-port handshakes; reset forces requests, acks and valids low at once.
    always_comb begin
        granted_s = n_reset && (st_q == ST_GRANT);
        mem_req   = granted_s && gnt_req_s;
        mem_addr  = addr[gnt_q*AN +: AN];
        mem_data  = data[gnt_q*DN +: DN];
        mem_wr    = wr[gnt_q];
        mem_id    = gnt_q;
        rdata     = mem_rdata;
        ack       = '0;
        if (granted_s && mem_ack) begin
            ack[gnt_q] = 1'b1;
        end else begin
            ack = '0;
        end
        valid = '0;
        for (int i = 0; i < N; i++) begin
            valid[i] = n_reset && mem_rvalid && (mem_rid == IDN'(i));
        end
    end

    // State register.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            st_q  <= ST_IDLE;
            gnt_q <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            gnt_q <= gnt_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_arbiter_rr_burst.sv
// Scoreboard bench for arbiter_rr_burst: three configurations driven by random stimulus,
// each compared against a transaction-level model of the arbitration rules.
`timescale 1ns/1ps
module tb_arbiter_rr_burst;
    typedef struct {
        int          cyc;
        logic        mreq;
        logic [3:0]  ack;
        logic [3:0]  valid;
        logic [1:0]  id;
        logic [23:0] addr;
        logic [15:0] data;
        logic        wr;
        logic [15:0] rdata;
    } exp_t;

    logic clk;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input bit ok, input string nm, input string detail);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s", nm, detail);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // k=0: 4 ports round-robin burst 2; k=1: 3 ports round-robin burst 3; k=2: 4 ports fixed priority burst 2
    for (genvar k = 0; k < 3; k++) begin : g
        localparam int NP = (k == 1) ? 3 : 4;
        localparam int MD = (k == 2) ? 0 : 1;
        localparam int BU = (k == 1) ? 3 : 2;

        logic             n_reset;
        logic [NP-1:0]    req, wr, ack, valid;
        logic [NP*24-1:0] addr;
        logic [NP*16-1:0] data;
        logic [15:0]      rdata, mem_data, mem_rdata;
        logic [23:0]      mem_addr;
        logic             mem_req, mem_wr, mem_ack, mem_rvalid;
        logic [1:0]       mem_id, mem_rid;

        bit      done  = 1'b0;
        bit      mdone = 1'b0;
        exp_t    q[$];
        int      own, beats, start, cyc;
        logic [NP-1:0] prev_ack;

        arbiter_rr_burst #(.N(NP), .AN(24), .DN(16), .IDN(2), .MODE(MD), .BURST(BU)) u_dut (
            .clk(clk), .n_reset(n_reset), .req(req), .addr(addr), .data(data), .wr(wr),
            .ack(ack), .valid(valid), .rdata(rdata), .mem_req(mem_req), .mem_addr(mem_addr),
            .mem_data(mem_data), .mem_wr(mem_wr), .mem_id(mem_id), .mem_ack(mem_ack),
            .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_rid(mem_rid)
        );

        function automatic int pick();
            for (int j = 0; j < NP; j++) begin
                int p;
                p = (MD == 1) ? (start + j) % NP : j;
                if (req[p]) return p;
            end
            return -1;
        endfunction

        // own = granted port or -1 when idle; start = first port a round-robin scan looks at
        task automatic model_update();
            if (!n_reset) begin
                own = -1; beats = 0; start = 0;
            end else if (own < 0) begin
                own = pick(); beats = 0;
            end else if (mem_ack) begin
                beats++;
                if (beats == BU) begin start = (own + 1) % NP; own = -1; end
            end else if (!req[own]) begin
                start = (own + 1) % NP; own = -1;
            end
        endtask

        task automatic drive(input int c);
            if (c == 0) n_reset = 1'b1;
            if (c == 12) n_reset = 1'b0;
            if (c == 15) n_reset = 1'b1;
            for (int i = 0; i < NP; i++) begin
                if (c == 12) begin
                    req[i] = 1'b0;
                end else if (!(req[i] && !prev_ack[i])) begin
                    addr[i*24 +: 24] = 24'($urandom);
                    data[i*16 +: 16] = 16'($urandom);
                    wr[i] = 1'($urandom);
                    if (c >= 1 && c <= 11) req[i] = 1'b1;
                    else if (c >= 15 && c <= 24) req[i] = (i == NP - 1);
                    else if (c >= 25) req[i] = ($urandom_range(0, 2) != 0);
                    else req[i] = 1'b0;
                end
            end
            mem_rdata  = 16'($urandom);
            mem_rid    = 2'($urandom);
            mem_rvalid = ($urandom_range(0, 2) == 0);
            if (c == 12) begin mem_rvalid = 1'b1; mem_rid = 2'd0; end
        endtask

        task automatic predict(input int c);
            exp_t e;
            e = '{default: '0};
            e.cyc = cyc;
            if (n_reset && own >= 0) e.mreq = req[own];
            if (c >= 1 && c <= 11) mem_ack = 1'b1;
            else if (c >= 12 && c <= 14) mem_ack = 1'b0;
            else mem_ack = e.mreq && ($urandom_range(0, 3) != 0);
            if (n_reset && own >= 0) begin
                if (mem_ack) e.ack = 4'b0001 << own;
                e.id   = 2'(own);
                e.addr = addr[own*24 +: 24];
                e.data = data[own*16 +: 16];
                e.wr   = wr[own];
            end
            if (n_reset && mem_rvalid && int'(mem_rid) < NP) begin
                e.valid = 4'b0001 << mem_rid;
                e.rdata = mem_rdata;
            end
            prev_ack = NP'(e.ack);
            if (e.mreq || e.ack != 4'b0 || e.valid != 4'b0) q.push_back(e);
        endtask

        initial begin
            n_reset = 1'b0; req = '0; addr = '0; data = '0; wr = '0;
            mem_ack = 1'b0; mem_rdata = 16'h0; mem_rvalid = 1'b1; mem_rid = 2'd0;
            own = -1; beats = 0; start = 0; cyc = 0; prev_ack = '0;
            repeat (2) @(posedge clk);
            #1;
            chk(mem_req == 1'b0 && ack == '0 && valid == '0, "reset_state",
                $sformatf("k=%0d got mem_req=%b ack=%b valid=%b, want all 0", k, mem_req, ack, valid));
            for (int c = 0; c < 700; c++) begin
                @(posedge clk);
                #1;
                model_update();
                cyc++;
                drive(c);
                predict(c);
                if (c == 12) begin
                    #1;
                    chk(mem_req == 1'b0 && ack == '0 && valid == '0, "reset_async",
                        $sformatf("k=%0d got mem_req=%b ack=%b valid=%b, want all 0", k, mem_req, ack, valid));
                end
            end
            done = 1'b1;
        end

        initial begin
            exp_t e;
            bit act;
            while (1'b1) begin
                @(negedge clk);
                act = mem_req || (ack != '0) || (valid != '0);
                if (act || (q.size() > 0 && q[0].cyc == cyc)) begin
                    chk(q.size() > 0, "unexpected_out",
                        $sformatf("k=%0d cyc=%0d got mem_req=%b ack=%b valid=%b, want no output", k, cyc, mem_req, ack, valid));
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        chk(e.cyc == cyc && e.mreq == mem_req && e.ack == 4'(ack) && e.valid == 4'(valid), "ctl",
                            $sformatf("k=%0d cyc=%0d got mem_req=%b ack=%b valid=%b, want cyc=%0d mem_req=%b ack=%b valid=%b",
                                      k, cyc, mem_req, ack, valid, e.cyc, e.mreq, e.ack, e.valid));
                        if (e.mreq && mem_req)
                            chk(mem_id == e.id && mem_addr == e.addr && mem_data == e.data && mem_wr == e.wr, "mux",
                                $sformatf("k=%0d cyc=%0d got id=%0d addr=%h data=%h wr=%b, want id=%0d addr=%h data=%h wr=%b",
                                          k, cyc, mem_id, mem_addr, mem_data, mem_wr, e.id, e.addr, e.data, e.wr));
                        if (e.valid != 4'b0)
                            chk(rdata == e.rdata, "rdata",
                                $sformatf("k=%0d cyc=%0d got %h want %h", k, cyc, rdata, e.rdata));
                    end
                end
                if (done) break;
            end
            chk(q.size() == 0, "drain", $sformatf("k=%0d got %0d pending outputs, want 0", k, q.size()));
            mdone = 1'b1;
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(g[0].mdone && g[1].mdone && g[2].mdone) && t < 20000) begin
            @(posedge clk);
            t++;
        end
        chk(g[0].mdone && g[1].mdone && g[2].mdone, "timeout",
            $sformatf("got done=%b%b%b after %0d cycles, want 111", g[0].mdone, g[1].mdone, g[2].mdone, t));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
